clause_cell: RTL and testbench

CLAUSE_CELL -- requirements
Module: clause_cell

---
 rtl/clause_cell.sv | 143 ++++++++++++++
 tb/tb_clause_cell.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clause_cell.sv
// Clause cell: stores one literal per variable slot, evaluates the clause against
// the attached var cells and emits unit implications or conflict marks.
module clause_cell #(
  parameter int NUM_VARS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*NUM_VARS-1:0] var_value_i,
  output logic [3*NUM_VARS-1:0] var_value_o,
  input  logic                  apply_load_i,
  input  logic                  apply_update_i,
  input  logic                  apply_analyze_i,
  input  logic                  learnt_slot_i,
  input  logic                  apply_backtrack_i,
  output logic                  clause_sat_o,
  output logic                  clause_conflict_o,
  output logic                  imply_o
);

  localparam int CW = $clog2(NUM_VARS + 1);

  typedef enum logic [1:0] {EMPTY, ACTIVE, IMPLY, CONFLICT} state_t;

  state_t                  state;
  logic [2*NUM_VARS-1:0]   lits;
  logic [2*NUM_VARS-1:0]   val_q;
  logic                    cap_q;

  logic [2*NUM_VARS-1:0]   in_vals;
  logic                    in_any;
  logic                    lits_any;
  logic                    sat_any;
  logic [CW-1:0]           nfalse;
  logic [CW-1:0]           nunas;
  logic [CW-1:0]           npres;
  logic [3*NUM_VARS-1:0]   unit_out;
  logic [3*NUM_VARS-1:0]   conf_out;
  logic [3*NUM_VARS-1:0]   upd_out;
  logic                    is_unit;
  logic                    is_conf;
  logic                    unused_implied;

  // A literal is present only for 01/10, so xor of its two bits is the present flag;
  // value 11 (conflict) falls into the false bucket.
  always_comb begin
    in_vals        = '0;
    in_any         = 1'b0;
    lits_any       = 1'b0;
    sat_any        = 1'b0;
    nfalse         = '0;
    nunas          = '0;
    npres          = '0;
    unit_out       = '0;
    conf_out       = '0;
    upd_out        = '0;
    unused_implied = 1'b0;
    for (int k = 0; k < NUM_VARS; k++) begin
      in_vals[2*k +: 2] = var_value_i[3*k+1 +: 2];
      unused_implied    = unused_implied ^ var_value_i[3*k];
      in_any            = in_any | (^var_value_i[3*k+1 +: 2]);
      lits_any          = lits_any | (^lits[2*k +: 2]);
      upd_out[3*k +: 3] = {lits[2*k +: 2], 1'b0};
      if (^lits[2*k +: 2]) begin
        npres             = npres + CW'(1);
        conf_out[3*k +: 3] = 3'b110;
        if (val_q[2*k +: 2] == 2'b00) begin
          nunas              = nunas + CW'(1);
          unit_out[3*k +: 3] = {lits[2*k +: 2], 1'b1};
        end else if (val_q[2*k +: 2] == lits[2*k +: 2]) begin
          sat_any = 1'b1;
        end else begin
          nfalse = nfalse + CW'(1);
        end
      end
    end
    is_unit = !sat_any && (nunas == CW'(1)) && (nfalse == npres - CW'(1));
    is_conf = !sat_any && (npres != '0) && (nfalse == npres);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= EMPTY;
      lits              <= '0;
      val_q             <= '0;
      cap_q             <= 1'b0;
      var_value_o       <= '0;
      clause_sat_o      <= 1'b0;
      clause_conflict_o <= 1'b0;
      imply_o           <= 1'b0;
    end else begin
      val_q             <= in_vals;
      var_value_o       <= '0;
      clause_sat_o      <= 1'b0;
      clause_conflict_o <= 1'b0;
      imply_o           <= 1'b0;
      if (apply_load_i) begin
        lits  <= in_vals;
        cap_q <= 1'b0;
        state <= in_any ? ACTIVE : EMPTY;
      end else if (apply_update_i) begin
        var_value_o       <= upd_out;
        clause_conflict_o <= (state == CONFLICT);
      end else if (apply_analyze_i) begin
        clause_conflict_o <= (state == CONFLICT);
        if (learnt_slot_i) begin
          lits  <= in_vals;
          cap_q <= 1'b1;
        end
      end else if (cap_q) begin
        // first cycle after a learnt-clause capture window closes
        cap_q <= 1'b0;
        state <= lits_any ? ACTIVE : EMPTY;
      end else begin
        case (state)
          ACTIVE: begin
            if (sat_any) begin
              clause_sat_o <= 1'b1;
            end else if (is_conf) begin
              state             <= CONFLICT;
              clause_conflict_o <= 1'b1;
              var_value_o       <= conf_out;
            end else if (is_unit) begin
              state       <= IMPLY;
              imply_o     <= 1'b1;
              var_value_o <= unit_out;
            end
          end
          IMPLY: state <= ACTIVE;
          CONFLICT: begin
            if (apply_backtrack_i) begin
              state <= ACTIVE;
            end else begin
              clause_conflict_o <= 1'b1;
              var_value_o       <= conf_out;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clause_cell.sv
// Directed bench for clause_cell (NUM_VARS=4): vector table plus multi-cycle sequences.
module tb_clause_cell;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vin, vout;
  logic        load, upd, ana, learnt, bt;
  logic        sat, conf, imp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clause_cell #(.NUM_VARS(4)) dut (
    .clk(clk), .rst(rst),
    .var_value_i(vin), .var_value_o(vout),
    .apply_load_i(load), .apply_update_i(upd), .apply_analyze_i(ana),
    .learnt_slot_i(learnt), .apply_backtrack_i(bt),
    .clause_sat_o(sat), .clause_conflict_o(conf), .imply_o(imp)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // slot 0 listed first; each slot driven as {value, implied=0}
  function automatic logic [11:0] v4(input logic [1:0] s0, s1, s2, s3);
    return {s3, 1'b0, s2, 1'b0, s1, 1'b0, s0, 1'b0};
  endfunction

  function automatic logic [11:0] o4(input logic [2:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_lits(input logic [11:0] l);
    vin  = l;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [11:0] lits;
    logic [11:0] vals;
    logic        sat;
    logic        conf;
    logic        imp;
    logic [11:0] out;
  } vec_t;

  vec_t tbl[9];
  logic [11:0] lits1;
  logic        any_imp;

  initial begin
    lits1 = v4(2'b01, 2'b10, 2'b00, 2'b01);
    tbl[0] = '{"unit_s3",   lits1, v4(2'b10,2'b01,2'b00,2'b00), 1'b0,1'b0,1'b1, o4(3'b000,3'b000,3'b000,3'b011)};
    tbl[1] = '{"conflict",  lits1, v4(2'b10,2'b01,2'b00,2'b10), 1'b0,1'b1,1'b0, o4(3'b110,3'b110,3'b000,3'b110)};
    tbl[2] = '{"sat",       lits1, v4(2'b01,2'b00,2'b00,2'b00), 1'b1,1'b0,1'b0, 12'h000};
    tbl[3] = '{"two_unas",  lits1, v4(2'b10,2'b00,2'b00,2'b00), 1'b0,1'b0,1'b0, 12'h000};
    tbl[4] = '{"lit11_abs", v4(2'b11,2'b10,2'b11,2'b00), v4(2'b01,2'b00,2'b10,2'b00),
               1'b0,1'b0,1'b1, o4(3'b000,3'b101,3'b000,3'b000)};
    tbl[5] = '{"empty",     v4(2'b00,2'b00,2'b00,2'b00), v4(2'b01,2'b00,2'b00,2'b00),
               1'b0,1'b0,1'b0, 12'h000};
    tbl[6] = '{"val11_false", v4(2'b01,2'b00,2'b00,2'b10), v4(2'b11,2'b00,2'b00,2'b00),
               1'b0,1'b0,1'b1, o4(3'b000,3'b000,3'b000,3'b101)};
    tbl[7] = '{"sat_w_v11", v4(2'b10,2'b10,2'b00,2'b00), v4(2'b11,2'b10,2'b00,2'b00),
               1'b1,1'b0,1'b0, 12'h000};
    tbl[8] = '{"single_conf", v4(2'b01,2'b00,2'b00,2'b00), v4(2'b10,2'b00,2'b00,2'b00),
               1'b0,1'b1,1'b0, o4(3'b110,3'b000,3'b000,3'b000)};

    rst = 1'b1; vin = '0; load = 0; upd = 0; ana = 0; learnt = 0; bt = 0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_outs", {19'd0, sat, conf, imp, vout}, 32'd0);

    // load, then apply values: evaluation of the new values lands on the second edge
    for (int i = 0; i < 9; i++) begin
      do_reset();
      load_lits(tbl[i].lits);
      vin = tbl[i].vals;
      tick(); tick();
      chk({tbl[i].nm, "_sat"},  sat,  tbl[i].sat);
      chk({tbl[i].nm, "_conf"}, conf, tbl[i].conf);
      chk({tbl[i].nm, "_imp"},  imp,  tbl[i].imp);
      chk({tbl[i].nm, "_out"},  vout, tbl[i].out);
    end

    // imply lasts exactly one cycle
    do_reset();
    load_lits(lits1);
    vin = v4(2'b10, 2'b01, 2'b00, 2'b00);
    tick(); tick();
    chk("imply_on", imp, 1'b1);
    tick();
    chk("imply_off", imp, 1'b0);
    chk("imply_off_out", vout, 12'h000);

    // conflict held until backtrack
    do_reset();
    load_lits(lits1);
    vin = v4(2'b10, 2'b01, 2'b00, 2'b10);
    tick(); tick(); tick(); tick();
    chk("conf_hold", conf, 1'b1);
    chk("conf_hold_out", vout, o4(3'b110, 3'b110, 3'b000, 3'b110));
    vin = v4(2'b01, 2'b01, 2'b00, 2'b10);
    bt = 1'b1;
    tick();
    bt = 1'b0;
    chk("bt_conf_clr", conf, 1'b0);
    chk("bt_out_clr", vout, 12'h000);
    tick();
    chk("bt_active_sat", sat, 1'b1);

    // update drives literals and holds state
    do_reset();
    load_lits(lits1);
    vin = v4(2'b01, 2'b00, 2'b00, 2'b00);
    tick(); tick();
    chk("upd_pre_sat", sat, 1'b1);
    bt = 1'b1;
    tick();
    bt = 1'b0;
    chk("bt_ignored", sat, 1'b1);
    upd = 1'b1;
    tick();
    chk("upd_out", vout, o4(3'b010, 3'b100, 3'b000, 3'b010));
    chk("upd_sat_low", sat, 1'b0);
    tick();
    chk("upd_out_hold", vout, o4(3'b010, 3'b100, 3'b000, 3'b010));
    upd = 1'b0;
    tick();
    chk("upd_rel_out", vout, 12'h000);
    chk("upd_rel_sat", sat, 1'b1);

    // learnt-clause capture
    do_reset();
    learnt = 1'b1;
    ana = 1'b1;
    vin = v4(2'b00, 2'b10, 2'b01, 2'b00);
    tick();
    chk("ana_out_zero", vout, 12'h000);
    tick();
    ana = 1'b0;
    vin = v4(2'b00, 2'b00, 2'b10, 2'b00);
    tick(); tick();
    chk("ana_imp", imp, 1'b1);
    chk("ana_imp_out", vout, o4(3'b000, 3'b101, 3'b000, 3'b000));
    tick();
    ana = 1'b1;
    vin = '0;
    tick(); tick();
    ana = 1'b0;
    vin = v4(2'b00, 2'b00, 2'b10, 2'b00);
    any_imp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      any_imp = any_imp | imp;
    end
    chk("ana_empty_no_imp", any_imp, 1'b0);
    learnt = 1'b0;

    // reset mid-conflict
    do_reset();
    load_lits(lits1);
    vin = v4(2'b10, 2'b01, 2'b00, 2'b10);
    tick(); tick();
    chk("pre_rst_conf", conf, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outs", {19'd0, sat, conf, imp, vout}, 32'd0);
    tick(); tick(); tick();
    chk("rst_lits_gone", {31'd0, conf}, 32'd0);

    // load beats update in the same cycle
    do_reset();
    vin  = lits1;
    load = 1'b1;
    upd  = 1'b1;
    tick();
    load = 1'b0;
    upd  = 1'b0;
    chk("load_wins_out", vout, 12'h000);
    vin = v4(2'b10, 2'b01, 2'b00, 2'b00);
    tick(); tick();
    chk("load_wins_imp", imp, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
